// File: rtl/xsched_pkg.sv
// Shared types and constants for the XOR-sharing scheduler.
package xsched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP_T1 = 3'd1,
    STEP_T2 = 3'd2,
    STEP_Z  = 3'd3,
    RESP    = 3'd4
  } state_e;

  localparam int unsigned OPW   = 4;
  localparam int unsigned A_BIT = 3;
  localparam int unsigned B_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned D_BIT = 0;

endpackage

// File: rtl/xsched_arb.sv
// Requester arbiter: round-robin from ptr when XSCHED_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module xsched_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  logic [NREQ-1:0] search_vec;

  assign any = |req_valid;

`ifdef XSCHED_RR_EN
  logic [NREQ-1:0] hi_req;

  // Requests at or above the pointer take precedence; wrap to the rest otherwise.
  always_comb begin
    hi_req = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      hi_req[i] = req_valid[i] && (i >= int'(ptr));
    end
    search_vec = (|hi_req) ? hi_req : req_valid;
  end
`else
  logic ptr_unused;

  assign ptr_unused = ^ptr;
  assign search_vec = req_valid;
`endif

  // Lowest set bit of the search vector wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (search_vec[i]) begin
        grant_onehot = NREQ'(1) << i;
        grant_idx    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/xor_share_sched.sv
// Time-multiplexes one external 2-input XOR cell to compute 4-input parity
// for NREQ requesters. Arbitration mode selected by XSCHED_RR_EN.
module xor_share_sched
  import xsched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_z,
  output logic              xor_a,
  output logic              xor_b,
  input  logic              xor_y,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   opnd_q, opnd_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             temp1_q, temp1_d;
  logic             temp2_q, temp2_d;
  logic             z_q, z_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  grant_onehot;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [OPW-1:0]   sel_data;

  xsched_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid    (req_valid),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  // Operand nibble of the winning requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_onehot[i]) sel_data = req_data[OPW*i +: OPW];
    end
  end

  // Next-state, datapath updates and XOR cell operand steering.
  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    id_d      = id_q;
    temp1_d   = temp1_q;
    temp2_d   = temp2_q;
    z_d       = z_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    xor_a     = 1'b0;
    xor_b     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready = grant_onehot;
          opnd_d    = sel_data;
          id_d      = grant_idx;
          ptr_d     = IDW'((32'(grant_idx) + 32'd1) % 32'(NREQ));
          state_d   = STEP_T1;
        end
      end
      STEP_T1: begin
        xor_a   = opnd_q[A_BIT];
        xor_b   = opnd_q[B_BIT];
        temp1_d = xor_y;
        state_d = STEP_T2;
      end
      STEP_T2: begin
        xor_a   = opnd_q[C_BIT];
        xor_b   = opnd_q[D_BIT];
        temp2_d = xor_y;
        state_d = STEP_Z;
      end
      STEP_Z: begin
        xor_a   = temp1_q;
        xor_b   = temp2_q;
        z_d     = xor_y;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      id_q        <= '0;
      temp1_q     <= 1'b0;
      temp2_q     <= 1'b0;
      z_q         <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      id_q        <= id_d;
      temp1_q     <= temp1_d;
      temp2_q     <= temp2_d;
      z_q         <= z_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef XSCHED_RR_EN
  // Round-robin pointer advances past each accepted requester.
  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  logic ptr_d_unused;

  assign ptr_d_unused = ^ptr_d;
  assign ptr_q        = '0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = z_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule
